cache_refill_ctrl: RTL and testbench

L0 instruction-cache miss/refill controller. It accepts a line-miss request from the cache lookup stage and takes a victim line index from the round-robin replacement pointer, advancing that pointer. It then fetches the line word by word over the OBI-style memory port, writes the words into the data array, and updates the tag and valid state. It sits between the L0 tag/data arrays, the replacement logic and the L1/memory interface.

---
 rtl/cache_l0_pkg.sv | 21 ++
 rtl/cache_valid_vec.sv | 59 +++++
 rtl/cache_refill_ctrl.sv | 143 ++++++++++++++
 tb/tb_cache_refill_ctrl.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_l0_pkg.sv
// Shared types and width helpers for the L0 instruction-cache refill path.
package cache_l0_pkg;

  localparam int unsigned WordBytes = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StDone  = 2'd2
  } refill_state_e;

  function automatic int unsigned offs_w(input int unsigned words_per_line);
    return $clog2(words_per_line) + $clog2(WordBytes);
  endfunction

  function automatic int unsigned tag_w(input int unsigned addr_w,
                                        input int unsigned words_per_line);
    return addr_w - offs_w(words_per_line);
  endfunction

endpackage

// File: rtl/cache_valid_vec.sv
// Per-line valid bits with set / clear-one / clear-all.
// With CACHE_REFILL_FLUSH_EN defined, flush requests clear all lines once the refill FSM is idle.
module cache_valid_vec import cache_l0_pkg::*; #(
  parameter int unsigned LOG2_NUM_BLKS = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          idle,
  input  logic                          flush,
  input  logic                          clr_en,
  input  logic [LOG2_NUM_BLKS-1:0]      clr_idx,
  input  logic                          set_en,
  input  logic [LOG2_NUM_BLKS-1:0]      set_idx,
  output logic [2**LOG2_NUM_BLKS-1:0]   valid,
  output logic                          flush_now
);

  localparam int unsigned NumLines = 2 ** LOG2_NUM_BLKS;

  logic [NumLines-1:0] valid_q, valid_d;

`ifdef CACHE_REFILL_FLUSH_EN
  logic pend_q, pend_d;

  // A flush seen while busy is deferred until the FSM is back in idle.
  assign flush_now = idle & (flush | pend_q);
  assign pend_d    = idle ? 1'b0 : (pend_q | flush);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
    end
  end
`else
  logic unused_flush;
  assign unused_flush = flush ^ idle;
  assign flush_now    = 1'b0;
`endif

  always_comb begin
    valid_d = valid_q;
    if (clr_en) valid_d[clr_idx] = 1'b0;
    if (set_en) valid_d[set_idx] = 1'b1;
    if (flush_now) valid_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  assign valid = valid_q;

endmodule

// File: rtl/cache_refill_ctrl.sv
// L0 I-cache miss/refill controller: claims a victim line, fetches it word by word, marks it valid.
// Optional flush support is enabled by defining CACHE_REFILL_FLUSH_EN.
module cache_refill_ctrl import cache_l0_pkg::*; #(
  parameter int unsigned LOG2_NUM_BLKS  = 3,
  parameter int unsigned WORDS_PER_LINE = 4,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      miss_i,
  input  logic [ADDR_W-1:0]                         miss_addr_i,
  output logic                                      busy_o,
  output logic                                      rplc_en_o,
  input  logic [LOG2_NUM_BLKS-1:0]                  rplc_line_idx_i,
  output logic                                      mem_req_o,
  output logic [ADDR_W-1:0]                         mem_addr_o,
  input  logic                                      mem_gnt_i,
  input  logic                                      mem_rvalid_i,
  input  logic [31:0]                               mem_rdata_i,
  output logic                                      line_we_o,
  output logic [LOG2_NUM_BLKS-1:0]                  line_idx_o,
  output logic [$clog2(WORDS_PER_LINE)-1:0]         line_word_o,
  output logic [31:0]                               line_wdata_o,
  output logic                                      tag_we_o,
  output logic [tag_w(ADDR_W, WORDS_PER_LINE)-1:0]  tag_o,
  output logic [2**LOG2_NUM_BLKS-1:0]               valid_o,
  output logic                                      refill_done_o,
  input  logic                                      flush_i
);

  localparam int unsigned OffsW = offs_w(WORDS_PER_LINE);
  localparam int unsigned TagW  = tag_w(ADDR_W, WORDS_PER_LINE);
  localparam int unsigned WordW = $clog2(WORDS_PER_LINE);
  localparam int unsigned CntW  = WordW + 1;

  localparam logic [CntW-1:0] CntFull = CntW'(WORDS_PER_LINE);
  localparam logic [CntW-1:0] CntLast = CntW'(WORDS_PER_LINE - 1);

  refill_state_e state_q, state_d;
  logic [TagW-1:0]          tag_q, tag_d;
  logic [LOG2_NUM_BLKS-1:0] victim_q, victim_d;
  logic [CntW-1:0]          gnt_cnt_q, gnt_cnt_d;
  logic [CntW-1:0]          rvalid_cnt_q, rvalid_cnt_d;

  logic fetch_req;
  logic valid_clr, valid_set;
  logic flush_now;

  logic [OffsW-1:0] unused_offs;
  assign unused_offs = miss_addr_i[OffsW-1:0];

  always_comb begin
    state_d      = state_q;
    tag_d        = tag_q;
    victim_d     = victim_q;
    gnt_cnt_d    = gnt_cnt_q;
    rvalid_cnt_d = rvalid_cnt_q;
    fetch_req    = 1'b0;
    rplc_en_o    = 1'b0;
    line_we_o    = 1'b0;
    tag_we_o     = 1'b0;
    refill_done_o = 1'b0;
    valid_clr    = 1'b0;
    valid_set    = 1'b0;

    unique case (state_q)
      StIdle: begin
        // A flush in idle takes priority; the miss is retried next cycle.
        if (miss_i && !flush_now) begin
          tag_d        = miss_addr_i[ADDR_W-1:OffsW];
          victim_d     = rplc_line_idx_i;
          gnt_cnt_d    = '0;
          rvalid_cnt_d = '0;
          rplc_en_o    = 1'b1;
          valid_clr    = 1'b1;
          state_d      = StFetch;
        end
      end
      StFetch: begin
        fetch_req = (gnt_cnt_q < CntFull);
        if (fetch_req && mem_gnt_i) begin
          gnt_cnt_d = gnt_cnt_q + CntW'(1);
        end
        if (mem_rvalid_i) begin
          line_we_o    = 1'b1;
          rvalid_cnt_d = rvalid_cnt_q + CntW'(1);
          if (rvalid_cnt_q == CntLast) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        tag_we_o      = 1'b1;
        refill_done_o = 1'b1;
        valid_set     = 1'b1;
        state_d       = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      tag_q        <= '0;
      victim_q     <= '0;
      gnt_cnt_q    <= '0;
      rvalid_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      tag_q        <= tag_d;
      victim_q     <= victim_d;
      gnt_cnt_q    <= gnt_cnt_d;
      rvalid_cnt_q <= rvalid_cnt_d;
    end
  end

  // Line base is tag_q with zero offset, so base + 4*gnt_cnt is a plain concatenation.
  assign mem_req_o    = fetch_req;
  assign mem_addr_o   = fetch_req ?
                        {tag_q, gnt_cnt_q[WordW-1:0], {(OffsW - WordW){1'b0}}} : '0;
  assign busy_o       = (state_q != StIdle);
  assign line_idx_o   = victim_q;
  assign line_word_o  = rvalid_cnt_q[WordW-1:0];
  assign line_wdata_o = mem_rdata_i;
  assign tag_o        = tag_q;

  cache_valid_vec #(
    .LOG2_NUM_BLKS (LOG2_NUM_BLKS)
  ) u_valid_vec (
    .clk       (clk),
    .rst_n     (rst_n),
    .idle      (state_q == StIdle),
    .flush     (flush_i),
    .clr_en    (valid_clr),
    .clr_idx   (rplc_line_idx_i),
    .set_en    (valid_set),
    .set_idx   (victim_q),
    .valid     (valid_o),
    .flush_now (flush_now)
  );

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Randomized bench for cache_refill_ctrl with an in-bench memory responder and line/valid model.
module tb_cache_refill_ctrl;

`ifdef CACHE_REFILL_FLUSH_EN
  localparam bit FlushEn = 1'b1;
`else
  localparam bit FlushEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        miss_i;
  logic [31:0] miss_addr_i;
  logic        busy_o;
  logic        rplc_en_o;
  logic [2:0]  rplc_line_idx_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        line_we_o;
  logic [2:0]  line_idx_o;
  logic [1:0]  line_word_o;
  logic [31:0] line_wdata_o;
  logic        tag_we_o;
  logic [27:0] tag_o;
  logic [7:0]  valid_o;
  logic        refill_done_o;
  logic        flush_i;

  always #5 clk = ~clk;

  cache_refill_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .miss_i          (miss_i),
    .miss_addr_i     (miss_addr_i),
    .busy_o          (busy_o),
    .rplc_en_o       (rplc_en_o),
    .rplc_line_idx_i (rplc_line_idx_i),
    .mem_req_o       (mem_req_o),
    .mem_addr_o      (mem_addr_o),
    .mem_gnt_i       (mem_gnt_i),
    .mem_rvalid_i    (mem_rvalid_i),
    .mem_rdata_i     (mem_rdata_i),
    .line_we_o       (line_we_o),
    .line_idx_o      (line_idx_o),
    .line_word_o     (line_word_o),
    .line_wdata_o    (line_wdata_o),
    .tag_we_o        (tag_we_o),
    .tag_o           (tag_o),
    .valid_o         (valid_o),
    .refill_done_o   (refill_done_o),
    .flush_i         (flush_i)
  );

  // External round-robin replacement pointer; the offset lets the first victim be line 2.
  logic [2:0] ptr_q;
  logic [2:0] ptr_ofs;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 3'd0;
    else if (rplc_en_o) ptr_q <= ptr_q + 3'd1;
  end
  assign rplc_line_idx_i = ptr_q + ptr_ofs;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int         exp_cnt;
  logic [7:0] exp_valid;

  // Observations of the most recent refill
  logic [31:0] obs_req[$];
  logic [31:0] obs_wdata[$];
  int          obs_word[$];
  int          obs_idx[$];
  logic [27:0] obs_tag;
  bit          obs_tag_we;
  int acc_k, done_k, first_req_k, last_rv_k, rplc_cnt, busy_gap;
  bit busy_at_acc, timed_out;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
  endfunction

  function automatic int exp_victim();
    return (exp_cnt + int'(ptr_ofs)) % 8;
  endfunction

  // Runs one miss through the DUT with a word-accurate memory responder and records what it saw.
  task automatic drive_refill(input logic [31:0] addr, input int stall_max, input bit hold,
                              input int flush_k);
    logic [31:0] pend_a[$];
    int          pend_t[$];
    int          gnt_wait;
    obs_req.delete(); obs_wdata.delete(); obs_word.delete(); obs_idx.delete();
    acc_k = -1; done_k = -1; first_req_k = -1; last_rv_k = -1;
    rplc_cnt = 0; busy_gap = 0; busy_at_acc = 1'b1; timed_out = 1'b0; obs_tag_we = 1'b0;
    gnt_wait = 0;
    for (int k = 0; k < 300 && done_k < 0; k++) begin
      @(negedge clk);
      miss_i      = hold || (acc_k < 0);
      miss_addr_i = addr;
      flush_i     = (k == flush_k);
      mem_gnt_i   = (gnt_wait == 0);
      if (pend_a.size() > 0 && pend_t[0] <= k) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = mem_word(pend_a[0]);
      end else begin
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = $urandom;
      end
      #1;
      if (rplc_en_o) begin
        rplc_cnt++;
        if (acc_k < 0) begin
          acc_k       = k;
          busy_at_acc = busy_o;
        end
      end
      if (acc_k >= 0 && k > acc_k && !busy_o) busy_gap++;
      if (mem_req_o) begin
        if (first_req_k < 0) first_req_k = k;
        if (mem_gnt_i) begin
          obs_req.push_back(mem_addr_o);
          pend_a.push_back(mem_addr_o);
          pend_t.push_back(k + 1 + int'($urandom_range(0, stall_max)));
        end
      end
      if (mem_req_o && mem_gnt_i) gnt_wait = int'($urandom_range(0, stall_max));
      else if (gnt_wait > 0) gnt_wait--;
      if (mem_rvalid_i) begin
        void'(pend_a.pop_front());
        void'(pend_t.pop_front());
      end
      if (line_we_o) begin
        obs_word.push_back(int'(line_word_o));
        obs_idx.push_back(int'(line_idx_o));
        obs_wdata.push_back(line_wdata_o);
        last_rv_k = k;
      end
      if (refill_done_o) begin
        done_k     = k;
        obs_tag    = tag_o;
        obs_tag_we = tag_we_o;
      end
    end
    if (done_k < 0) timed_out = 1'b1;
    mem_rvalid_i = 1'b0;
    mem_gnt_i    = 1'b0;
    flush_i      = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; miss_i = 1'b0; miss_addr_i = '0; mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b0; mem_rdata_i = '0; flush_i = 1'b0; ptr_ofs = 3'd2;
    exp_cnt = 0; exp_valid = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    total++;
    if ({busy_o, rplc_en_o, mem_req_o, line_we_o, tag_we_o, refill_done_o} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got %b want 000000",
               {busy_o, rplc_en_o, mem_req_o, line_we_o, tag_we_o, refill_done_o});
    end
    total++;
    if (mem_addr_o !== 32'h0) begin
      bad++; $display("FAIL reset_addr: got %h want 00000000", mem_addr_o);
    end
    total++;
    if (valid_o !== 8'h00) begin
      bad++; $display("FAIL reset_valid: got %h want 00", valid_o);
    end
  endtask

  task automatic test_basic();
    int v;
    v = exp_victim();
    drive_refill(32'h0000_1234, 0, 1'b0, -1);
    total++;
    if (timed_out) begin bad++; $display("FAIL basic_timeout: got none want refill_done"); end
    total++;
    if (obs_req.size() != 4) begin
      bad++; $display("FAIL basic_nreq: got %0d want 4", obs_req.size());
    end
    for (int i = 0; i < obs_req.size() && i < 4; i++) begin
      total++;
      if (obs_req[i] !== 32'h1230 + 32'(4 * i)) begin
        bad++; $display("FAIL basic_addr%0d: got %h want %h", i, obs_req[i], 32'h1230 + 32'(4 * i));
      end
    end
    total++;
    if (obs_wdata.size() != 4) begin
      bad++; $display("FAIL basic_nwr: got %0d want 4", obs_wdata.size());
    end
    for (int i = 0; i < obs_wdata.size() && i < 4; i++) begin
      total++;
      if (obs_word[i] != i || obs_idx[i] != 2 ||
          obs_wdata[i] !== mem_word(32'h1230 + 32'(4 * i))) begin
        bad++;
        $display("FAIL basic_wr%0d: got word %0d line %0d data %h want word %0d line 2 data %h",
                 i, obs_word[i], obs_idx[i], obs_wdata[i], i, mem_word(32'h1230 + 32'(4 * i)));
      end
    end
    total++;
    if (obs_tag !== 28'h123 || !obs_tag_we) begin
      bad++; $display("FAIL basic_tag: got %h we %0d want 0000123 we 1", obs_tag, obs_tag_we);
    end
    total++;
    if (first_req_k - acc_k != 1 || last_rv_k - acc_k != 5 || done_k - acc_k != 6) begin
      bad++;
      $display("FAIL basic_timing: got req %0d last_rv %0d done %0d want 1 5 6",
               first_req_k - acc_k, last_rv_k - acc_k, done_k - acc_k);
    end
    total++;
    if (rplc_cnt != 1) begin bad++; $display("FAIL basic_rplc: got %0d want 1", rplc_cnt); end
    exp_valid[v] = 1'b1;
    exp_cnt++;
    @(negedge clk); #1;
    total++;
    if (valid_o !== exp_valid) begin
      bad++; $display("FAIL basic_valid: got %h want %h", valid_o, exp_valid);
    end
  endtask

  task automatic test_random_stalls();
    logic [31:0] addr, base;
    int v, nerr;
    for (int n = 0; n < 6; n++) begin
      addr = $urandom;
      base = {addr[31:4], 4'h0};
      v = exp_victim();
      drive_refill(addr, 5, 1'b0, -1);
      total++;
      if (timed_out) begin bad++; $display("FAIL rnd_timeout%0d: got none want refill_done", n); end
      nerr = 0;
      if (obs_req.size() != 4 || obs_wdata.size() != 4) nerr++;
      for (int i = 0; i < obs_req.size() && i < 4; i++)
        if (obs_req[i] !== base + 32'(4 * i)) nerr++;
      for (int i = 0; i < obs_wdata.size() && i < 4; i++)
        if (obs_word[i] != i || obs_idx[i] != v || obs_wdata[i] !== mem_word(base + 32'(4 * i)))
          nerr++;
      total++;
      if (nerr != 0) begin
        bad++;
        $display("FAIL rnd_writes%0d: got %0d reqs %0d writes with %0d wrong want 4 4 0 (line %0d)",
                 n, obs_req.size(), obs_wdata.size(), nerr, v);
      end
      total++;
      if (obs_tag !== addr[31:4]) begin
        bad++; $display("FAIL rnd_tag%0d: got %h want %h", n, obs_tag, addr[31:4]);
      end
      total++;
      if (rplc_cnt != 1 || busy_gap != 0) begin
        bad++; $display("FAIL rnd_rplc%0d: got pulses %0d gaps %0d want 1 0", n, rplc_cnt, busy_gap);
      end
      exp_valid[v] = 1'b1;
      exp_cnt++;
      @(negedge clk); #1;
      total++;
      if (valid_o !== exp_valid) begin
        bad++; $display("FAIL rnd_valid%0d: got %h want %h", n, valid_o, exp_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    int v1, v2;
    a = $urandom; b = $urandom;
    v1 = exp_victim();
    drive_refill(a, 0, 1'b1, -1);
    total++;
    if (timed_out || rplc_cnt != 1 || done_k - acc_k != 6 || busy_gap != 0) begin
      bad++;
      $display("FAIL b2b_first: got timeout %0d pulses %0d done %0d gaps %0d want 0 1 6 0",
               timed_out, rplc_cnt, done_k - acc_k, busy_gap);
    end
    exp_valid[v1] = 1'b1;
    exp_cnt++;
    v2 = exp_victim();
    drive_refill(b, 0, 1'b1, -1);
    total++;
    if (acc_k != 0 || busy_at_acc !== 1'b0) begin
      bad++; $display("FAIL b2b_accept: got cycle %0d busy %0d want 0 0", acc_k, busy_at_acc);
    end
    total++;
    if (obs_idx.size() != 4 || obs_idx[0] != v2 || obs_idx[3] != v2) begin
      bad++;
      $display("FAIL b2b_victim: got %0d writes first line %0d want 4 line %0d",
               obs_idx.size(), (obs_idx.size() > 0) ? obs_idx[0] : -1, v2);
    end
    total++;
    if (obs_tag !== b[31:4] || rplc_cnt != 1 || done_k - acc_k != 6) begin
      bad++;
      $display("FAIL b2b_second: got tag %h pulses %0d done %0d want %h 1 6",
               obs_tag, rplc_cnt, done_k - acc_k, b[31:4]);
    end
    exp_valid[v2] = 1'b1;
    exp_cnt++;
    @(negedge clk); miss_i = 1'b0; #1;
    total++;
    if (valid_o !== exp_valid) begin
      bad++; $display("FAIL b2b_valid: got %h want %h", valid_o, exp_valid);
    end
  endtask

  task automatic test_reset_mid();
    int nwr;
    nwr = 0;
    @(negedge clk);
    miss_i = 1'b1; miss_addr_i = $urandom; mem_gnt_i = 1'b1; mem_rvalid_i = 1'b0;
    @(negedge clk); miss_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      mem_rvalid_i = 1'b1; mem_rdata_i = $urandom;
      #1;
      if (line_we_o) nwr++;
    end
    total++;
    if (nwr != 2) begin bad++; $display("FAIL rstmid_writes: got %0d want 2", nwr); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy_o, rplc_en_o, mem_req_o, line_we_o, tag_we_o, refill_done_o} !== 6'b0 ||
        mem_addr_o !== 32'h0 || valid_o !== 8'h00) begin
      bad++;
      $display("FAIL rstmid_outputs: got ctrl %b addr %h valid %h want 000000 00000000 00",
               {busy_o, rplc_en_o, mem_req_o, line_we_o, tag_we_o, refill_done_o},
               mem_addr_o, valid_o);
    end
    exp_cnt = 0;
    exp_valid = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      mem_rvalid_i = 1'b1; mem_rdata_i = $urandom;
      #1;
      total++;
      if (line_we_o !== 1'b0 || busy_o !== 1'b0) begin
        bad++; $display("FAIL rstmid_stray%0d: got we %b busy %b want 0 0", k, line_we_o, busy_o);
      end
    end
    @(negedge clk);
    mem_rvalid_i = 1'b0; mem_gnt_i = 1'b0;
  endtask

  task automatic fill_all(input string name);
    int v, nto;
    nto = 0;
    for (int n = 0; n < 8; n++) begin
      v = exp_victim();
      drive_refill($urandom, 2, 1'b0, -1);
      if (timed_out) nto++;
      exp_valid[v] = 1'b1;
      exp_cnt++;
    end
    @(negedge clk); #1;
    total++;
    if (nto != 0 || valid_o !== exp_valid) begin
      bad++; $display("FAIL %s: got valid %h timeouts %0d want %h 0", name, valid_o, nto, exp_valid);
    end
  endtask

  task automatic test_flush();
    fill_all("flush_fill1");
    flush_i = 1'b1;
    @(negedge clk); flush_i = 1'b0; #1;
    if (FlushEn) exp_valid = 8'h00;
    total++;
    if (valid_o !== exp_valid) begin
      bad++; $display("FAIL flush_idle: got %h want %h", valid_o, exp_valid);
    end
    fill_all("flush_fill2");
    drive_refill($urandom, 0, 1'b0, 3);
    total++;
    if (timed_out) begin bad++; $display("FAIL flush_mid_timeout: got none want refill_done"); end
    exp_cnt++;
    @(negedge clk); #1;
    total++;
    if (valid_o !== 8'hFF) begin
      bad++; $display("FAIL flush_mid_idle: got %h want ff", valid_o);
    end
    if (FlushEn) exp_valid = 8'h00;
    @(negedge clk); #1;
    total++;
    if (valid_o !== exp_valid) begin
      bad++; $display("FAIL flush_mid_after: got %h want %h", valid_o, exp_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random_stalls();
    test_back_to_back();
    test_reset_mid();
    test_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion want $finish");
    $fatal(1, "watchdog expired");
  end

endmodule
